// File: rtl/wb_irq_csr_bank_if.sv
// Wishbone-lite register bus used by wb_irq_csr_bank: single-cycle ack, registered read data.
interface wb_irq_csr_bank_if #(
   parameter int ADDR_W = 8
);
   logic              valid_i;
   logic              we_i;
   logic [3:0]        sel_i;
   logic [ADDR_W-1:0] adr_i;
   logic [31:0]       dat_i;
   logic [31:0]       dat_o;
   logic              ack_o;

   modport master (
      output valid_i, we_i, sel_i, adr_i, dat_i,
      input  dat_o, ack_o
   );

   modport slave (
      input  valid_i, we_i, sel_i, adr_i, dat_i,
      output dat_o, ack_o
   );
endinterface

// File: rtl/wb_irq_csr_bank.sv
// Wishbone CSR bank: sticky IRQ pending with edge/level mode, enable mask, byte-writable control words.
// Optional feature macro CSR_IRQ_SYNC_EN: 2-flop input synchronisers plus the SET register at 0x18.
module wb_irq_csr_bank #(
   parameter int          NSRC    = 4,
   parameter int          NCTRL   = 2,
   parameter int          ADDR_W  = 8,
   parameter logic [31:0] VERSION = 32'h0200_0000
) (
   input  logic                clk_i,
   input  logic                rst_i,
   wb_irq_csr_bank_if.slave    bus,
   input  logic [NSRC-1:0]     irq_src_i,
   input  logic [NSRC-1:0]     act_i,
   output logic [NCTRL*32-1:0] ctrl_o,
   output logic                irq_o
);

   localparam int WA = ADDR_W - 2;

   localparam logic [WA-1:0] A_STATUS  = WA'(0);
   localparam logic [WA-1:0] A_RAW     = WA'(1);
   localparam logic [WA-1:0] A_PENDING = WA'(2);
   localparam logic [WA-1:0] A_MODE    = WA'(3);
   localparam logic [WA-1:0] A_ENABLE  = WA'(4);
   localparam logic [WA-1:0] A_VERSION = WA'(5);
`ifdef CSR_IRQ_SYNC_EN
   localparam logic [WA-1:0] A_SET     = WA'(6);
`endif
   localparam logic [WA-1:0] A_CTRL    = WA'(8);

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [31:0] mask);
      return (old_val & ~mask) | (new_val & mask);
   endfunction

   // ------------------------------------------------------------------
   // Source conditioning
   // ------------------------------------------------------------------
   logic [NSRC-1:0] src;
   logic [NSRC-1:0] act;

`ifdef CSR_IRQ_SYNC_EN
   logic [NSRC-1:0] src_meta;
   logic [NSRC-1:0] act_meta;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         src_meta <= '0;
         act_meta <= '0;
         src      <= '0;
         act      <= '0;
      end else begin
         src_meta <= irq_src_i;
         act_meta <= act_i;
         src      <= src_meta;
         act      <= act_meta;
      end
   end
`else
   assign src = irq_src_i;
   assign act = act_i;
`endif

   // ------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------
   logic          access;
   logic          wr;
   logic          rd;
   logic [WA-1:0] word;
   logic [31:0]   bmask;
   logic          unused_adr;

   // A new access is accepted only while ack is low, so held valid acks every other cycle.
   assign access     = bus.valid_i && !bus.ack_o;
   assign wr         = access && bus.we_i;
   assign rd         = access && !bus.we_i;
   assign word       = bus.adr_i[ADDR_W-1:2];
   assign bmask      = {{8{bus.sel_i[3]}}, {8{bus.sel_i[2]}}, {8{bus.sel_i[1]}}, {8{bus.sel_i[0]}}};
   assign unused_adr = ^bus.adr_i[1:0];

   // ------------------------------------------------------------------
   // Register state
   // ------------------------------------------------------------------
   logic [NSRC-1:0] pending_q;
   logic [NSRC-1:0] mode_q;
   logic [NSRC-1:0] enable_q;
   logic [NSRC-1:0] src_q;
   logic [31:0]     ctrl_q [NCTRL];

   logic [NSRC-1:0] set_hw;
   logic [NSRC-1:0] set_sw;
   logic [NSRC-1:0] w1c;
   logic [NSRC-1:0] pending_d;
   logic [NSRC-1:0] mode_d;
   logic [NSRC-1:0] enable_d;
   logic [31:0]     mode_wr;
   logic [31:0]     enable_wr;
   logic [31:0]     rdata;

   assign mode_wr   = merge_bytes(32'(mode_q),   bus.dat_i, bmask);
   assign enable_wr = merge_bytes(32'(enable_q), bus.dat_i, bmask);

   // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      set_hw   = (mode_q & src & ~src_q) | (~mode_q & src);
      set_sw   = '0;
      w1c      = '0;
      mode_d   = mode_q;
      enable_d = enable_q;

      if (wr) begin
         case (word)
            A_PENDING: w1c      = bus.dat_i[NSRC-1:0];
            A_MODE:    mode_d   = mode_wr[NSRC-1:0];
            A_ENABLE:  enable_d = enable_wr[NSRC-1:0];
`ifdef CSR_IRQ_SYNC_EN
            A_SET:     set_sw   = bus.dat_i[NSRC-1:0];
`endif
            default: ;
         endcase
      end

      // Clear is applied first so a same-cycle set always wins.
      pending_d = (pending_q & ~w1c) | set_hw | set_sw;
   end

   always_comb begin
      rdata = '0;
      case (word)
         A_STATUS:  rdata = 32'(act);
         A_RAW:     rdata = 32'(src);
         A_PENDING: rdata = 32'(pending_q);
         A_MODE:    rdata = 32'(mode_q);
         A_ENABLE:  rdata = 32'(enable_q);
         A_VERSION: rdata = VERSION;
         default: ;
      endcase
      for (int k = 0; k < NCTRL; k++) begin
         if (word == A_CTRL + WA'(k)) rdata = ctrl_q[k];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bus.ack_o <= 1'b0;
         bus.dat_o <= '0;
         irq_o     <= 1'b0;
         pending_q <= '0;
         mode_q    <= '0;
         enable_q  <= '0;
         src_q     <= '0;
         // NOTE: the control array is small and architecturally reset to zero, so it is reset here.
         for (int k = 0; k < NCTRL; k++) ctrl_q[k] <= '0;
      end else begin
         bus.ack_o <= access;
         if (rd) bus.dat_o <= rdata;
         irq_o     <= |(pending_q & enable_q);
         pending_q <= pending_d;
         mode_q    <= mode_d;
         enable_q  <= enable_d;
         src_q     <= src;
         for (int k = 0; k < NCTRL; k++) begin
            if (wr && word == A_CTRL + WA'(k)) ctrl_q[k] <= merge_bytes(ctrl_q[k], bus.dat_i, bmask);
         end
      end
   end

   for (genvar k = 0; k < NCTRL; k++) begin : g_ctrl
      assign ctrl_o[32*k +: 32] = ctrl_q[k];
   end

endmodule
